// File: rtl/i2s_transmitter_pkg.sv
// Shared audio constants for the I2S transmit path.
// Holds the sample width, slot length and BCLK divider used by the
// interpolator and the transmitter, so both agree on the 96 kHz frame
// (512 master clocks per frame). Also holds the channel encoding of the
// word-select line.
package i2s_transmitter_pkg;

    localparam int I2S_DATA_WIDTH    = 24;
    localparam int I2S_SLOT_BITS     = 32;
    localparam int I2S_BCLK_DIV_LOG2 = 3;

    // Master clocks per frame: two slots of SLOT_BITS bit clocks each.
    function automatic int i2s_frame_clks(input int slot_bits, input int div_log2);
        return 2 * slot_bits * (1 << div_log2);
    endfunction

    // Width of the frame counter: BCLK phase + slot bit index + channel.
    function automatic int i2s_cnt_width(input int slot_bits, input int div_log2);
        return div_log2 + $clog2(slot_bits) + 1;
    endfunction

    localparam int I2S_FRAME_CLKS = i2s_frame_clks(I2S_SLOT_BITS, I2S_BCLK_DIV_LOG2);

    // LRCLK level for each channel (Philips I2S: 0 = left).
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_chan_e;

endpackage

// File: rtl/i2s_tx_shifter.sv
// One channel's slot shift register.
// On load it takes a sample and frames it as a full slot: one leading
// zero (the I2S one-bit delay), the sample MSB first, then zero padding.
// Each shift moves the next slot bit to slot_bit; zeros fill in behind,
// so every bit past the sample reads 0.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         synchronous clear of the slot register
//   load          take load_data as the next slot
//   load_data     sample, two's complement
//   shift         advance one slot bit
//   slot_bit      current slot bit (register MSB)
module i2s_tx_shifter #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    output logic                  slot_bit
);

    localparam int PAD_BITS = SLOT_BITS - 1 - DATA_WIDTH;

    logic [SLOT_BITS-1:0] slot_reg;
    logic [SLOT_BITS-1:0] slot_next;
    logic [SLOT_BITS-1:0] load_slot;

    // Zero-extend then push the sample up against the leading zero bit.
    assign load_slot = {{(SLOT_BITS - DATA_WIDTH){1'b0}}, load_data} << PAD_BITS;

    always_comb begin
        slot_next = slot_reg;
        if (clear) begin
            slot_next = '0;
        end else if (load) begin
            slot_next = load_slot;
        end else if (shift) begin
            slot_next = {slot_reg[SLOT_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign slot_bit = slot_reg[SLOT_BITS-1];

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter for the 96 kHz L/R sample stream.
// A free-running frame counter produces BCLK (clk/8) and LRCLK (clk/512)
// as flop outputs. Incoming L/R strobes fill a one-deep holding stage; a
// completed pair becomes pending and is moved into the per-channel slot
// shifters at the last count of the frame. A frame that starts with no
// pending pair raises the sticky underrun flag; a pair completed while an
// unconsumed one is still pending replaces it and raises overrun.
// Optional build macro I2S_TX_REPEAT_ON_UNDERRUN_EN: when defined, an
// underrun frame repeats the last transmitted pair instead of zeros.
// Ports:
//   clk, reset_n              master clock, asynchronous active-low reset
//   run                       enable; low clears counter, flags and shifters
//   l/r_din_valid, l/r_data_in  sample strobes and data
//   bclk, lrclk, sdata        I2S pins
//   frame_start               pulse in the first cycle of a freshly loaded frame
//   underrun, overrun         sticky status
//   test_data                 debug snapshot of internal state
module i2s_transmitter
    import i2s_transmitter_pkg::*;
#(
    parameter int DATA_WIDTH    = I2S_DATA_WIDTH,
    parameter int BCLK_DIV_LOG2 = I2S_BCLK_DIV_LOG2,
    parameter int SLOT_BITS     = I2S_SLOT_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  l_din_valid,
    input  logic                  r_din_valid,
    input  logic [DATA_WIDTH-1:0] l_data_in,
    input  logic [DATA_WIDTH-1:0] r_data_in,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  frame_start,
    output logic                  underrun,
    output logic                  overrun,
    output logic [15:0]           test_data
);

    localparam int CNT_W      = i2s_cnt_width(SLOT_BITS, BCLK_DIV_LOG2);
    localparam int FRAME_CLKS = i2s_frame_clks(SLOT_BITS, BCLK_DIV_LOG2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);

    logic [CNT_W-1:0]       cnt_reg;
    logic                   bclk_reg;
    logic                   lrclk_reg;
    logic                   sdata_reg;
    logic                   frame_start_reg;
    logic                   underrun_reg;
    logic                   overrun_reg;
    logic                   pending_reg;

    logic [1:0]             din_valid;
    logic [DATA_WIDTH-1:0]  din [2];
    logic [1:0]             got_vec;
    logic [1:0]             slot_bit_vec;
    logic                   load;
    logic                   bit_edge;
    logic                   pair_done;
    i2s_chan_e              chan;
    logic [$clog2(SLOT_BITS)-1:0] slot_idx;

    assign din_valid = {r_din_valid, l_din_valid};
    assign din[0]    = l_data_in;
    assign din[1]    = r_data_in;

    assign load      = run && (cnt_reg == CNT_LAST);
    assign bit_edge  = run && (cnt_reg[BCLK_DIV_LOG2-1:0] == '0);
    assign pair_done = &got_vec;
    assign chan      = i2s_chan_e'(cnt_reg[CNT_W-1]);
    assign slot_idx  = cnt_reg[CNT_W-2:BCLK_DIV_LOG2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            localparam i2s_chan_e GEN_CH = (gi == 0) ? CH_LEFT : CH_RIGHT;

            logic [DATA_WIDTH-1:0] hold_reg;
            logic                  got_reg;
            logic [DATA_WIDTH-1:0] load_data;

            // A strobe wins over the pair-complete clear so a sample
            // arriving right as the pair is taken is not lost.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hold_reg <= '0;
                    got_reg  <= 1'b0;
                end else if (!run) begin
                    got_reg  <= 1'b0;
                end else if (din_valid[gi]) begin
                    hold_reg <= din[gi];
                    got_reg  <= 1'b1;
                end else if (pair_done) begin
                    got_reg  <= 1'b0;
                end
            end

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            logic [DATA_WIDTH-1:0] last_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    last_reg <= '0;
                end else if (load && pending_reg) begin
                    last_reg <= hold_reg;
                end
            end

            assign load_data = pending_reg ? hold_reg : last_reg;
`else
            assign load_data = pending_reg ? hold_reg : '0;
`endif

            assign got_vec[gi] = got_reg;

            i2s_tx_shifter #(
                .DATA_WIDTH (DATA_WIDTH),
                .SLOT_BITS  (SLOT_BITS)
            ) u_shifter (
                .clk       (clk),
                .reset_n   (reset_n),
                .clear     (!run),
                .load      (load),
                .load_data (load_data),
                .shift     (bit_edge && (chan == GEN_CH)),
                .slot_bit  (slot_bit_vec[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg         <= '0;
            bclk_reg        <= 1'b0;
            lrclk_reg       <= 1'b0;
            sdata_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
            pending_reg     <= 1'b0;
        end else if (!run) begin
            cnt_reg         <= '0;
            bclk_reg        <= 1'b0;
            lrclk_reg       <= 1'b0;
            sdata_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
            pending_reg     <= 1'b0;
        end else begin
            cnt_reg         <= cnt_reg + 1'b1;
            bclk_reg        <= cnt_reg[BCLK_DIV_LOG2-1];
            lrclk_reg       <= cnt_reg[CNT_W-1];
            frame_start_reg <= load && pending_reg;
            // The current slot bit is sampled before this edge's shift.
            if (bit_edge) begin
                sdata_reg <= (chan == CH_RIGHT) ? slot_bit_vec[1] : slot_bit_vec[0];
            end
            if (load && !pending_reg) begin
                underrun_reg <= 1'b1;
            end
            // A pair completing in the load cycle is kept for the next frame,
            // so it only counts as an overwrite when nothing is consumed.
            if (pair_done && pending_reg && !load) begin
                overrun_reg <= 1'b1;
            end
            if (pair_done) begin
                pending_reg <= 1'b1;
            end else if (load) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign bclk        = bclk_reg;
    assign lrclk       = lrclk_reg;
    assign sdata       = sdata_reg;
    assign frame_start = frame_start_reg;
    assign underrun    = underrun_reg;
    assign overrun     = overrun_reg;
    assign test_data   = {pending_reg, got_vec[0], got_vec[1], lrclk_reg, bclk_reg,
                          underrun_reg, overrun_reg, 5'(slot_idx), 4'b0000};

endmodule

// File: tb/tb_i2s_transmitter.sv
module tb_i2s_transmitter;
    import i2s_transmitter_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        l_din_valid;
    logic        r_din_valid;
    logic [23:0] l_data_in;
    logic [23:0] r_data_in;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame_start;
    logic        underrun;
    logic        overrun;
    logic [15:0] test_data;

    int checks   = 0;
    int failures = 0;
    int tb_cnt   = 0;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    typedef struct {
        logic        s1;
        logic [23:0] l1;
        logic [23:0] r1;
        int          l_at;
        int          r_at;
        logic        s2;
        logic [23:0] l2;
        logic [23:0] r2;
        int          at2;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        logic        exp_fs;
        logic        exp_ur;
        logic        exp_ov;
    } frame_t;

    i2s_transmitter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .l_din_valid (l_din_valid),
        .r_din_valid (r_din_valid),
        .l_data_in   (l_data_in),
        .r_data_in   (r_data_in),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun),
        .test_data   (test_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame position: equals the count the design should hold.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cnt <= 0;
        else if (!run) tb_cnt <= 0;
        else tb_cnt <= (tb_cnt + 1) % I2S_FRAME_CLKS;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one frame from count 0: drives the record's strobes, collects
    // both transmitted slots, flags at count 0 and the clock waveform.
    task automatic do_frame(input frame_t v, input bit wave_en,
                            output logic [31:0] lw, output logic [31:0] rw,
                            output logic fs, output logic ur, output logic ov,
                            output int bad);
        int t;
        int prev;
        int k;
        lw  = '0;
        rw  = '0;
        fs  = 1'bx;
        ur  = 1'bx;
        ov  = 1'bx;
        bad = 0;
        for (int i = 0; i < I2S_FRAME_CLKS; i++) begin
            t = tb_cnt;
            if (t == 0) begin
                fs = frame_start;
                ur = underrun;
                ov = overrun;
            end
            prev = (t + I2S_FRAME_CLKS - 1) % I2S_FRAME_CLKS;
            if (wave_en && ((bclk !== prev[2]) || (lrclk !== prev[8]))) bad++;
            if (t % 8 == 1) begin
                k = ((t - 1) / 8) % 32;
                if ((t - 1) / 256 == 0) lw[31-k] = sdata;
                else                    rw[31-k] = sdata;
            end
            l_din_valid = (v.s1 && t == v.l_at) || (v.s2 && t == v.at2);
            r_din_valid = (v.s1 && t == v.r_at) || (v.s2 && t == v.at2);
            l_data_in   = (v.s2 && t == v.at2) ? v.l2 : v.l1;
            r_data_in   = (v.s2 && t == v.at2) ? v.r2 : v.r1;
            step();
        end
        l_din_valid = 1'b0;
        r_din_valid = 1'b0;
    endtask

    initial begin
        frame_t      vec [9];
        logic [31:0] lw, rw;
        logic        fs, ur, ov;
        int          bad;
        logic [31:0] rep_cl, rep_cr, rep_2;

        rep_cl = REPEAT ? 32'h55E6F780 : 32'h0;
        rep_cr = REPEAT ? 32'h08888880 : 32'h0;
        rep_2  = REPEAT ? 32'h00000100 : 32'h0;

        //          s1    l1          r1          l_at r_at s2    l2          r2          at2  exp_l          exp_r          fs    ur    ov
        vec[0] = '{1'b1, 24'h800001, 24'h7FFFFE, 100, 100, 1'b0, 24'h000000, 24'h000000, 0,   32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 24'h123456, 24'h654321, 10,  300, 1'b0, 24'h000000, 24'h000000, 0,   32'h40000080, 32'h3FFFFF00, 1'b1, 1'b0, 1'b0};
        vec[2] = '{1'b1, 24'hABCDEF, 24'h111111, 50,  50,  1'b0, 24'h000000, 24'h000000, 0,   32'h091A2B00, 32'h32A19080, 1'b1, 1'b0, 1'b0};
        vec[3] = '{1'b0, 24'h000000, 24'h000000, 0,   0,   1'b0, 24'h000000, 24'h000000, 0,   32'h55E6F780, 32'h08888880, 1'b1, 1'b0, 1'b0};
        vec[4] = '{1'b0, 24'h000000, 24'h000000, 0,   0,   1'b0, 24'h000000, 24'h000000, 0,   rep_cl,       rep_cr,       1'b0, 1'b1, 1'b0};
        vec[5] = '{1'b1, 24'h000001, 24'h000001, 20,  20,  1'b1, 24'h000002, 24'h000002, 200, rep_cl,       rep_cr,       1'b0, 1'b1, 1'b0};
        vec[6] = '{1'b1, 24'h5A5A5A, 24'hA5A5A5, 510, 510, 1'b0, 24'h000000, 24'h000000, 0,   32'h00000100, 32'h00000100, 1'b1, 1'b1, 1'b1};
        vec[7] = '{1'b0, 24'h000000, 24'h000000, 0,   0,   1'b0, 24'h000000, 24'h000000, 0,   rep_2,        rep_2,        1'b0, 1'b1, 1'b1};
        vec[8] = '{1'b0, 24'h000000, 24'h000000, 0,   0,   1'b0, 24'h000000, 24'h000000, 0,   32'h2D2D2D00, 32'h52D2D280, 1'b1, 1'b1, 1'b1};

        reset_n     = 1'b0;
        run         = 1'b0;
        l_din_valid = 1'b0;
        r_din_valid = 1'b0;
        l_data_in   = '0;
        r_data_in   = '0;

        // Reset and idle.
        repeat (3) step();
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 0);
        check("rst_sdata", sdata, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);
        check("rst_test_data", test_data, 0);
        reset_n = 1'b1;
        repeat (3) step();
        check("idle_bclk", bclk, 0);
        check("idle_sdata", sdata, 0);
        check("idle_frame_start", frame_start, 0);
        check("idle_test_data", test_data, 0);

        // Frame table: each frame transmits the previous frame's pair.
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            do_frame(vec[i], i > 0, lw, rw, fs, ur, ov, bad);
            check($sformatf("f%0d_left_slot", i), lw, vec[i].exp_l);
            check($sformatf("f%0d_right_slot", i), rw, vec[i].exp_r);
            check($sformatf("f%0d_frame_start", i), fs, vec[i].exp_fs);
            check($sformatf("f%0d_underrun", i), ur, vec[i].exp_ur);
            check($sformatf("f%0d_overrun", i), ov, vec[i].exp_ov);
            if (i > 0) check($sformatf("f%0d_clk_wave_errors", i), bad, 0);
            $display("frame %0d left=%h right=%h fs=%0b ur=%0b ov=%0b wave_err=%0d",
                     i, lw, rw, fs, ur, ov, bad);
        end

        // Drop run mid-frame at count 200.
        for (int i = 0; i < 600 && tb_cnt != 200; i++) step();
        check("drop_at_cnt", tb_cnt, 200);
        check("drop_pre_bclk", bclk, 1);
        check("drop_pre_underrun", underrun, 1);
        run = 1'b0;
        step();
        check("drop_bclk", bclk, 0);
        check("drop_lrclk", lrclk, 0);
        check("drop_sdata", sdata, 0);
        check("drop_frame_start", frame_start, 0);
        check("drop_underrun", underrun, 0);
        check("drop_overrun", overrun, 0);
        check("drop_test_data", test_data, 0);
        $display("run drop bclk=%0b lrclk=%0b sdata=%0b ur=%0b ov=%0b td=%h",
                 bclk, lrclk, sdata, underrun, overrun, test_data);
        repeat (3) step();

        // Restart: counter begins at 0, so LRCLK rises 257 cycles later.
        run = 1'b1;
        step();
        check("restart_lrclk_low", lrclk, 0);
        check("restart_bit_index", test_data[8:4], 0);
        repeat (255) step();
        check("restart_lrclk_before_right", lrclk, 0);
        step();
        check("restart_lrclk_right", lrclk, 1);
        $display("restart lrclk=%0b", lrclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
